// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte producers.
// Sequences load / byte-ready / start strobes and waits for end-of-frame, with a watchdog.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned GAP_CYCLES     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 4095
) (
   input  logic                            CLOCK,
   input  logic                            RESET,
   input  logic [NUM_REQ-1:0]              REQ_VALID,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   REQ_DATA,
   output logic [NUM_REQ-1:0]              REQ_READY,
   input  logic                            ERR_CLR,
   input  logic                            TX_CLEAR,
   output logic [DATA_WIDTH-1:0]           TX_DATA,
   output logic                            LOAD_XMT_DATAREG,
   output logic                            BYTE_READY,
   output logic                            T_BYTE,
   output logic [$clog2(NUM_REQ)-1:0]      GRANT_ID,
   output logic                            BUSY,
   output logic                            TIMEOUT_ERR
);

   localparam int unsigned IdW    = $clog2(NUM_REQ);
   localparam int unsigned CntMax = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
   localparam int unsigned CntW   = (CntMax < 1) ? 1 : $clog2(CntMax + 1);
   localparam logic [CntW-1:0] ToLast  = CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
   localparam logic [CntW-1:0] GapLast = CntW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StLoad, StArm, StStart, StWaitDone, StGap} state_e;

   state_e                 state_q, state_d;
   logic [IdW-1:0]         ptr_q, ptr_d;
   logic [IdW-1:0]         grant_q, grant_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
   logic                   err_q, err_d;
   logic                   load_q, byte_rdy_q, t_byte_q, busy_q;
   logic [IdW-1:0]         win;
   logic [IdW:0]           idx;
   logic                   found;
   logic                   expire;

   // First valid requester at or after ptr_q, wrapping modulo NUM_REQ.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, ptr_q} + (IdW+1)'(k);
         if (idx >= (IdW+1)'(NUM_REQ)) idx = idx - (IdW+1)'(NUM_REQ);
         if (!found && REQ_VALID[idx[IdW-1:0]]) begin
            found = 1'b1;
            win   = idx[IdW-1:0];
         end
      end
   end

   always_comb begin
      REQ_READY = '0;
      if (state_q == StIdle && found && !RESET) REQ_READY[win] = 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      cnt_d     = cnt_q;
      tx_data_d = tx_data_q;
      err_d     = err_q;
      expire    = 1'b0;
      if (ERR_CLR) err_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               tx_data_d = REQ_DATA[win*DATA_WIDTH +: DATA_WIDTH];
               grant_d   = win;
               ptr_d     = (win == IdW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
               state_d   = StLoad;
            end
         end
         StLoad:  state_d = StArm;
         StArm:   state_d = StStart;
         StStart: begin
            cnt_d   = '0;
            state_d = StWaitDone;
         end
         StWaitDone: begin
            cnt_d  = cnt_q + 1'b1;
            expire = (TIMEOUT_CYCLES != 0) && (cnt_q == ToLast);
            // TX_CLEAR beats a coincident expiry; a set beats ERR_CLR.
            if (TX_CLEAR || expire) begin
               if (!TX_CLEAR) err_d = 1'b1;
               cnt_d   = '0;
               state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
            end
         end
         StGap: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == GapLast) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q    <= StIdle;
         ptr_q      <= '0;
         grant_q    <= '0;
         cnt_q      <= '0;
         tx_data_q  <= '0;
         err_q      <= 1'b0;
         load_q     <= 1'b0;
         byte_rdy_q <= 1'b0;
         t_byte_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         grant_q    <= grant_d;
         cnt_q      <= cnt_d;
         tx_data_q  <= tx_data_d;
         err_q      <= err_d;
         load_q     <= (state_d == StLoad);
         byte_rdy_q <= (state_d == StArm);
         t_byte_q   <= (state_d == StStart);
         busy_q     <= (state_d != StIdle);
      end
   end

   assign TX_DATA          = tx_data_q;
   assign LOAD_XMT_DATAREG = load_q;
   assign BYTE_READY       = byte_rdy_q;
   assign T_BYTE           = t_byte_q;
   assign GRANT_ID         = grant_q;
   assign BUSY             = busy_q;
   assign TIMEOUT_ERR      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance with GAP=2/TIMEOUT=8, one with GAP=0/no watchdog.
module tb_uart_tx_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic        rst;
   logic [3:0]  vld_a, rdy_a, vld_b, rdy_b;
   logic [31:0] data_a, data_b;
   logic        clr_a, clr_b, eclr_a, eclr_b;
   logic [7:0]  txd_a, txd_b;
   logic        ld_a, br_a, tb_a, busy_a, terr_a;
   logic        ld_b, br_b, tb_b, busy_b, terr_b;
   logic [1:0]  gid_a, gid_b;

   uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .GAP_CYCLES(2), .TIMEOUT_CYCLES(8)) dut_a (
      .CLOCK(clk), .RESET(rst), .REQ_VALID(vld_a), .REQ_DATA(data_a), .REQ_READY(rdy_a),
      .ERR_CLR(eclr_a), .TX_CLEAR(clr_a), .TX_DATA(txd_a), .LOAD_XMT_DATAREG(ld_a),
      .BYTE_READY(br_a), .T_BYTE(tb_a), .GRANT_ID(gid_a), .BUSY(busy_a), .TIMEOUT_ERR(terr_a)
   );

   uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .GAP_CYCLES(0), .TIMEOUT_CYCLES(0)) dut_b (
      .CLOCK(clk), .RESET(rst), .REQ_VALID(vld_b), .REQ_DATA(data_b), .REQ_READY(rdy_b),
      .ERR_CLR(eclr_b), .TX_CLEAR(clr_b), .TX_DATA(txd_b), .LOAD_XMT_DATAREG(ld_b),
      .BYTE_READY(br_b), .T_BYTE(tb_b), .GRANT_ID(gid_b), .BUSY(busy_b), .TIMEOUT_ERR(terr_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One frame on dut_a starting in an idle cycle; TX_CLEAR at cycle clr_at, ends on next idle.
   task automatic run_frame(input logic [3:0] v, input int clr_at,
                            output logic [3:0] rdy0, output logic [1:0] gid1);
      rdy0 = 'x;
      gid1 = 'x;
      for (int c = 0; c <= clr_at + 2; c++) begin
         vld_a = v;
         clr_a = (c == clr_at);
         @(negedge clk);
         if (c == 0) rdy0 = rdy_a;
         if (c == 1) gid1 = gid_a;
         tick();
      end
      vld_a = '0;
      clr_a = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      @(negedge clk);
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got %b expected 0", busy_a); end
      checks++; if ({ld_a, br_a, tb_a} !== 3'b000) begin failures++; $display("FAIL reset_strobes got %b expected 000", {ld_a, br_a, tb_a}); end
      checks++; if (txd_a !== 8'h00 || gid_a !== 2'd0) begin failures++; $display("FAIL reset_data got txd=%h gid=%0d expected 00/0", txd_a, gid_a); end
      checks++; if (terr_a !== 1'b0 || rdy_a !== 4'b0000) begin failures++; $display("FAIL reset_err_rdy got %b/%b expected 0/0000", terr_a, rdy_a); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_round_robin();
      int exp_g [5] = '{0, 1, 2, 3, 0};
      logic [3:0] r;
      logic [1:0] g;
      for (int f = 0; f < 5; f++) begin
         run_frame(4'b1111, 8, r, g);
         checks++; if (r !== (4'b0001 << exp_g[f])) begin failures++; $display("FAIL rr_ready[%0d] got %b expected %b", f, r, 4'b0001 << exp_g[f]); end
         checks++; if (g !== 2'(exp_g[f])) begin failures++; $display("FAIL rr_grant[%0d] got %0d expected %0d", f, g, exp_g[f]); end
      end
   endtask

   task automatic test_single();
      for (int c = 0; c <= 13; c++) begin
         vld_a = (c == 0) ? 4'b0100 : 4'b0000;
         clr_a = (c == 10);
         @(negedge clk);
         checks++; if (rdy_a !== ((c == 0) ? 4'b0100 : 4'b0000)) begin failures++; $display("FAIL single_ready c%0d got %b", c, rdy_a); end
         if (c >= 1) begin
            checks++; if (txd_a !== 8'hA5 || gid_a !== 2'd2) begin failures++; $display("FAIL single_data c%0d got %h/%0d expected a5/2", c, txd_a, gid_a); end
         end
         checks++; if ({ld_a, br_a, tb_a} !== {c == 1, c == 2, c == 3}) begin failures++; $display("FAIL single_strobes c%0d got %b expected %b", c, {ld_a, br_a, tb_a}, {c == 1, c == 2, c == 3}); end
         checks++; if (busy_a !== (c >= 1 && c <= 12)) begin failures++; $display("FAIL single_busy c%0d got %b expected %b", c, busy_a, c >= 1 && c <= 12); end
         tick();
      end
      clr_a = 1'b0;
   endtask

   // Pointer is 3 here: only requester 1 valid wins, then 0 and 2 valid grants 2.
   task automatic test_wrap_skip();
      logic [3:0] r;
      logic [1:0] g;
      run_frame(4'b0010, 8, r, g);
      checks++; if (r !== 4'b0010 || g !== 2'd1) begin failures++; $display("FAIL wrap_grant got %b/%0d expected 0010/1", r, g); end
      run_frame(4'b0101, 8, r, g);
      checks++; if (r !== 4'b0100 || g !== 2'd2) begin failures++; $display("FAIL skip_grant got %b/%0d expected 0100/2", r, g); end
      checks++; if (txd_a !== 8'hA5) begin failures++; $display("FAIL skip_data got %h expected a5", txd_a); end
   endtask

   task automatic test_watchdog();
      for (int c = 0; c <= 14; c++) begin
         vld_a  = (c == 0) ? 4'b0001 : 4'b0000;
         eclr_a = (c == 11);
         @(negedge clk);
         checks++; if (terr_a !== (c >= 12)) begin failures++; $display("FAIL wd_err c%0d got %b expected %b", c, terr_a, c >= 12); end
         checks++; if (busy_a !== (c >= 1 && c <= 13)) begin failures++; $display("FAIL wd_busy c%0d got %b expected %b", c, busy_a, c >= 1 && c <= 13); end
         tick();
      end
      eclr_a = 1'b1;
      @(negedge clk);
      checks++; if (terr_a !== 1'b1) begin failures++; $display("FAIL wd_sticky got %b expected 1", terr_a); end
      tick();
      eclr_a = 1'b0;
      @(negedge clk);
      checks++; if (terr_a !== 1'b0) begin failures++; $display("FAIL wd_errclr got %b expected 0", terr_a); end
      tick();
      for (int c = 0; c <= 14; c++) begin
         vld_a = (c == 0) ? 4'b0001 : 4'b0000;
         clr_a = (c == 11);
         @(negedge clk);
         checks++; if (terr_a !== 1'b0) begin failures++; $display("FAIL wd_coincide c%0d got %b expected 0", c, terr_a); end
         checks++; if (busy_a !== (c >= 1 && c <= 13)) begin failures++; $display("FAIL wd_co_busy c%0d got %b", c, busy_a); end
         tick();
      end
      clr_a = 1'b0;
   endtask

   task automatic test_spurious_clear();
      for (int c = 0; c <= 11; c++) begin
         vld_a = (c == 0) ? 4'b0001 : 4'b0000;
         clr_a = (c == 1 || c == 8 || c == 9);
         @(negedge clk);
         checks++; if ({ld_a, br_a, tb_a} !== {c == 1, c == 2, c == 3}) begin failures++; $display("FAIL spur_strobes c%0d got %b", c, {ld_a, br_a, tb_a}); end
         checks++; if (busy_a !== (c >= 1 && c <= 10)) begin failures++; $display("FAIL spur_busy c%0d got %b expected %b", c, busy_a, c >= 1 && c <= 10); end
         tick();
      end
      clr_a = 1'b0;
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c <= 4; c++) begin
         vld_a = (c == 0) ? 4'b0100 : 4'b1000;
         tick();
      end
      rst = 1'b1;
      tick();
      @(negedge clk);
      checks++; if ({busy_a, ld_a, br_a, tb_a, terr_a} !== 5'b0) begin failures++; $display("FAIL rmid_flags got %b expected 00000", {busy_a, ld_a, br_a, tb_a, terr_a}); end
      checks++; if (txd_a !== 8'h00 || gid_a !== 2'd0 || rdy_a !== 4'b0000) begin failures++; $display("FAIL rmid_regs got %h/%0d/%b expected 00/0/0000", txd_a, gid_a, rdy_a); end
      tick();
      rst = 1'b0;
      @(negedge clk);
      checks++; if (rdy_a !== 4'b1000) begin failures++; $display("FAIL rmid_accept got %b expected 1000", rdy_a); end
      tick();
      vld_a = '0;
      @(negedge clk);
      checks++; if (gid_a !== 2'd3 || txd_a !== 8'h3C || ld_a !== 1'b1) begin failures++; $display("FAIL rmid_grant got %0d/%h/%b expected 3/3c/1", gid_a, txd_a, ld_a); end
      for (int c = 1; c <= 6; c++) begin
         clr_a = (c == 4);
         tick();
      end
      clr_a = 1'b0;
      @(negedge clk);
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rmid_idle got %b expected 0", busy_a); end
      tick();
   endtask

   task automatic test_gap_zero();
      for (int c = 0; c <= 10; c++) begin
         vld_b = (c == 0) ? 4'b0001 : ((c >= 9) ? 4'b0010 : 4'b0000);
         clr_b = (c == 8);
         @(negedge clk);
         if (c == 8) begin
            checks++; if (busy_b !== 1'b1) begin failures++; $display("FAIL gap0_wait got %b expected 1", busy_b); end
         end
         if (c == 9) begin
            checks++; if (rdy_b !== 4'b0010 || busy_b !== 1'b0) begin failures++; $display("FAIL gap0_accept got %b/%b expected 0010/0", rdy_b, busy_b); end
         end
         if (c == 10) begin
            checks++; if (gid_b !== 2'd1 || ld_b !== 1'b1 || txd_b !== 8'h22) begin failures++; $display("FAIL gap0_grant got %0d/%b/%h expected 1/1/22", gid_b, ld_b, txd_b); end
         end
         tick();
      end
      vld_b = '0;
      clr_b = 1'b0;
      for (int c = 0; c < 22; c++) tick();
      @(negedge clk);
      checks++; if (terr_b !== 1'b0 || busy_b !== 1'b1) begin failures++; $display("FAIL gap0_nowd got %b/%b expected 0/1", terr_b, busy_b); end
      clr_b = 1'b1;
      tick();
      clr_b = 1'b0;
      @(negedge clk);
      checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL gap0_done got %b expected 0", busy_b); end
      tick();
   endtask

   initial begin
      rst    = 1'b1;
      vld_a  = '0;
      vld_b  = '0;
      clr_a  = 1'b0;
      clr_b  = 1'b0;
      eclr_a = 1'b0;
      eclr_b = 1'b0;
      data_a = 32'h3CA5_5A17;
      data_b = 32'h4433_2211;
      test_reset();
      test_round_robin();
      test_single();
      test_wrap_skip();
      test_watchdog();
      test_spurious_clear();
      test_reset_mid();
      test_gap_zero();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
